// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the fetch
// unit and the program loader.
//
// BOOT lets only the loader reach the memory. RUN lets both requesters in,
// with at most one grant per cycle. Read data from the memory arrives one
// cycle after the address. A one-bit owner tag steers that data back to the
// requester that issued the read.
//
// Build option: define IMEM_ARB_RR_EN to replace fixed loader priority in
// RUN with a one-bit round-robin pointer. With the macro undefined, the
// loader always wins a conflict.
//
// Request/grant handshake (both ports): a requester holds *_req high with
// its address (and write data) stable. *_gnt is combinational and comes in
// the same cycle as the request. A cycle with *_req && *_gnt is one accepted
// access. Without a grant, the request is not consumed and must be held or
// re-presented. The result of an accepted read shows up as *_rvalid for
// exactly the following cycle. Accepted writes produce no *_rvalid.
//
// boot_done is a direct view of the FSM state register (0 = BOOT, 1 = RUN).

module imem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    // fetch port (read-only)
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,

    // loader port (read/write)
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    input  logic                  l_done,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,

    // instruction memory (read data one cycle after address)
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  boot_done
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Owner tag encoding for the pending read return.
    localparam logic OWN_FETCH  = 1'b0;
    localparam logic OWN_LOADER = 1'b1;

    logic [0:0]            state_q,  state_d;
    logic                  rd_pend_q, rd_pend_d;   // a granted read returns next cycle
    logic                  owner_q,  owner_d;      // who issued that read
    logic [DATA_WIDTH-1:0] f_hold_q, f_hold_d;     // last fetch read data
    logic [DATA_WIDTH-1:0] l_hold_q, l_hold_d;     // last loader read data

`ifdef IMEM_ARB_RR_EN
    logic                  rr_q, rr_d;             // 1: loader was granted most recently
`endif

    logic                  any_gnt;
    logic                  rd_gnt;

    // BOOT/RUN sequencing: leave BOOT on the edge that samples l_done; RUN holds until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && l_done) begin
            state_d = ST_RUN;
        end
    end

    // Grant selection; nothing is granted while reset is asserted
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst) begin
            if (state_q == ST_BOOT) begin
                // Program load phase: the loader owns the memory outright.
                l_gnt = l_req;
            end else begin
`ifdef IMEM_ARB_RR_EN
                if (l_req && f_req) begin
                    // Conflict: hand the slot to whoever was not served last.
                    l_gnt = ~rr_q;
                    f_gnt = rr_q;
                end else begin
                    l_gnt = l_req;
                    f_gnt = f_req;
                end
`else
                l_gnt = l_req;
                f_gnt = f_req & ~l_req;
`endif
            end
        end
    end

    // Memory-side steering from the winning requester
    always_comb begin
        mem_addr  = l_gnt ? l_addr : f_addr;
        mem_we    = l_gnt & l_we;
        mem_wdata = l_wdata;
    end

    // Read tracking: any granted non-write access expects data next cycle
    always_comb begin
        any_gnt   = f_gnt | l_gnt;
        rd_gnt    = any_gnt & ~(l_gnt & l_we);
        rd_pend_d = rd_gnt;
        owner_d   = l_gnt ? OWN_LOADER : OWN_FETCH;
    end

`ifdef IMEM_ARB_RR_EN
    // Round-robin pointer remembers the most recent grant of any kind
    always_comb begin
        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = l_gnt;
        end
    end
`endif

    // Return path: route the memory data to the tagged owner, hold otherwise.
    // A return pending when reset is asserted is dropped.
    always_comb begin
        f_rvalid = rst & rd_pend_q & (owner_q == OWN_FETCH);
        l_rvalid = rst & rd_pend_q & (owner_q == OWN_LOADER);
        f_hold_d = f_rvalid ? mem_rdata : f_hold_q;
        l_hold_d = l_rvalid ? mem_rdata : l_hold_q;
        f_rdata  = f_hold_d;
        l_rdata  = l_hold_d;
        boot_done = (state_q == ST_RUN);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            rd_pend_q <= 1'b0;
            owner_q   <= OWN_FETCH;
            f_hold_q  <= '0;
            l_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
            f_hold_q  <= f_hold_d;
            l_hold_q  <= l_hold_d;
        end
    end

`ifdef IMEM_ARB_RR_EN
    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed boot/run scenarios plus randomized traffic.
// A transaction-level model checks every DUT output every cycle.
module tb_imem_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_done, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          boot_done;

  imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .boot_done(boot_done)
  );

  // instruction memory: synchronous, one cycle read latency
  logic [DW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    mem_rdata <= env_mem[mem_addr];
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state: memory image, boot flag, last-grant side,
  // per-port last delivered data, and in-flight reads (data + owner)
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_booted = 1'b0;
  bit            m_last_l = 1'b0;
  logic [DW-1:0] m_f_last = '0;
  logic [DW-1:0] m_l_last = '0;
  logic [DW-1:0] exp_q [$];
  bit            own_q [$];

  // compare process: outputs are settled mid-cycle, check them all
  always @(negedge clk) begin : model
    bit            e_fg, e_lg, e_fv, e_lv, e_we, r_own;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] r_dat;
    e_fg = 1'b0;
    e_lg = 1'b0;
    if (rst) begin
      if (!m_booted) begin
        e_lg = l_req;
      end else if (l_req && f_req) begin
`ifdef IMEM_ARB_RR_EN
        e_lg = !m_last_l;
        e_fg = m_last_l;
`else
        e_lg = 1'b1;
`endif
      end else begin
        e_lg = l_req;
        e_fg = f_req;
      end
    end
    e_addr = e_lg ? l_addr : f_addr;
    e_we   = e_lg && l_we;
    e_fv   = 1'b0;
    e_lv   = 1'b0;
    if (exp_q.size() > 0) begin
      r_dat = exp_q.pop_front();
      r_own = own_q.pop_front();
      if (rst) begin
        if (r_own) begin e_lv = 1'b1; m_l_last = r_dat; end
        else       begin e_fv = 1'b1; m_f_last = r_dat; end
      end
    end
    chk("f_gnt",     64'(f_gnt),     64'(e_fg));
    chk("l_gnt",     64'(l_gnt),     64'(e_lg));
    chk("f_rvalid",  64'(f_rvalid),  64'(e_fv));
    chk("l_rvalid",  64'(l_rvalid),  64'(e_lv));
    chk("f_rdata",   64'(f_rdata),   64'(m_f_last));
    chk("l_rdata",   64'(l_rdata),   64'(m_l_last));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_we",    64'(mem_we),    64'(e_we));
    chk("mem_wdata", 64'(mem_wdata), 64'(l_wdata));
    chk("boot_done", 64'(boot_done), 64'(m_booted));
    if (mem_we === 1'b1) we_cnt++;
    // advance model to the next cycle
    if (!rst) begin
      m_booted = 1'b0;
      m_last_l = 1'b0;
      m_f_last = '0;
      m_l_last = '0;
      exp_q.delete();
      own_q.delete();
    end else begin
      if (l_done) m_booted = 1'b1;
      if (e_fg || e_lg) m_last_l = e_lg;
      if ((e_fg || e_lg) && !e_we) begin
        exp_q.push_back(ref_mem[e_addr]);
        own_q.push_back(e_lg);
      end
      if (e_we) ref_mem[e_addr] = l_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] exp_l;
  initial begin
`ifdef IMEM_ARB_RR_EN
    exp_l = 4'b0101;
`else
    exp_l = 4'b1111;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    rst = 1'b0;
    idle();

    // reset state
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("rst boot_done", 64'(boot_done), 64'd0);
        chk("rst f_rvalid",  64'(f_rvalid),  64'd0);
        chk("rst l_rvalid",  64'(l_rvalid),  64'd0);
        chk("rst f_rdata",   64'(f_rdata),   64'd0);
        chk("rst l_rdata",   64'(l_rdata),   64'd0);
      end
      next_cycle();
    end
    rst = 1'b1;

    // fetch is locked out while booting
    for (int i = 0; i < 5; i++) begin
      f_req = 1'b1;
      f_addr = AW'($urandom_range(0, 15));
      @(negedge clk);
      chk("boot f_gnt", 64'(f_gnt), 64'd0);
      chk("boot boot_done", 64'(boot_done), 64'd0);
      next_cycle();
    end
    idle();

    // program load: two writes, then l_done
    we_cnt = 0;
    l_req = 1'b1; l_we = 1'b1; l_addr = AW'(0); l_wdata = 32'h2008_0005;
    @(negedge clk);
    chk("load0 l_gnt", 64'(l_gnt), 64'd1);
    next_cycle();
    l_addr = AW'(1); l_wdata = 32'h2009_0003;
    @(negedge clk);
    chk("load1 l_gnt", 64'(l_gnt), 64'd1);
    next_cycle();
    idle();
    l_done = 1'b1;
    @(negedge clk);
    chk("done boot_done", 64'(boot_done), 64'd0);
    next_cycle();
    l_done = 1'b0;
    @(negedge clk);
    chk("run boot_done", 64'(boot_done), 64'd1);
    next_cycle();
    chk("load we count", 64'(we_cnt), 64'd2);

    // back-to-back fetches over addresses 0..9
    for (int i = 0; i <= 10; i++) begin
      f_req = (i < 10);
      f_addr = AW'(i % 10);
      @(negedge clk);
      if (i < 10) chk("fetch f_gnt", 64'(f_gnt), 64'd1);
      if (i >= 1) chk("fetch f_rvalid", 64'(f_rvalid), 64'd1);
      if (i == 1) chk("fetch rdata0", 64'(f_rdata), 64'h2008_0005);
      if (i == 2) chk("fetch rdata1", 64'(f_rdata), 64'h2009_0003);
      next_cycle();
    end
    idle();

    // simultaneous loader read and fetch
    for (int k = 0; k < 4; k++) begin
      f_req = 1'b1; f_addr = AW'($urandom_range(0, 15));
      l_req = 1'b1; l_we = 1'b0; l_addr = AW'(1);
      @(negedge clk);
      chk("conflict l_gnt", 64'(l_gnt), 64'(exp_l[k]));
      chk("conflict f_gnt", 64'(f_gnt), 64'(!exp_l[k]));
      if (k == 1) begin
        chk("conflict l_rvalid", 64'(l_rvalid), 64'd1);
        chk("conflict l_rdata", 64'(l_rdata), 64'h2009_0003);
      end
      next_cycle();
    end
    idle();
    next_cycle();

    // randomized traffic with occasional resets and l_done pulses
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      l_done  = ($urandom_range(0, 15) == 0);
      f_req   = $urandom_range(0, 1) == 1;
      f_addr  = AW'($urandom_range(0, 15));
      l_req   = $urandom_range(0, 1) == 1;
      l_we    = $urandom_range(0, 1) == 1;
      l_addr  = AW'($urandom_range(0, 15));
      l_wdata = $urandom;
      next_cycle();
    end
    rst = 1'b1;
    idle();

    // reset right after a granted fetch drops its return
    l_done = 1'b1;
    next_cycle();
    idle();
    next_cycle();
    f_req = 1'b1; f_addr = AW'(0);
    @(negedge clk);
    chk("pre-rst f_gnt", 64'(f_gnt), 64'd1);
    next_cycle();
    f_req = 1'b0;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    f_req = 1'b1;
    @(negedge clk);
    chk("post-rst f_rvalid",  64'(f_rvalid),  64'd0);
    chk("post-rst l_rvalid",  64'(l_rvalid),  64'd0);
    chk("post-rst boot_done", 64'(boot_done), 64'd0);
    chk("post-rst f_rdata",   64'(f_rdata),   64'd0);
    chk("post-rst l_rdata",   64'(l_rdata),   64'd0);
    chk("post-rst f_gnt",     64'(f_gnt),     64'd0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the word-address width of the instruction memory.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port f_req  in  1  fetch-side read request.
REQ-006 SHALL have port f_addr  in  ADDR_WIDTH  fetch read address.
REQ-007 SHALL have port f_gnt  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port f_rvalid  out  1  f_rdata valid this cycle.
REQ-009 SHALL have port f_rdata  out  DATA_WIDTH  fetch read data.
REQ-010 SHALL have port l_req  in  1  loader request (read or write).
REQ-011 SHALL have port l_we  in  1  loader write enable, qualified by l_req.
REQ-012 SHALL have port l_addr  in  ADDR_WIDTH  loader address.
REQ-013 SHALL have port l_wdata  in  DATA_WIDTH  loader write data.
REQ-014 SHALL have port l_done  in  1  single-cycle pulse: program load complete.
REQ-015 SHALL have port l_gnt  out  1  loader request accepted this cycle.
REQ-016 SHALL have port l_rvalid  out  1  l_rdata valid this cycle.
REQ-017 SHALL have port l_rdata  out  DATA_WIDTH  loader read data.
REQ-018 SHALL have ports mem_addr (out, ADDR_WIDTH), mem_we (out, 1), mem_wdata (out, DATA_WIDTH), mem_rdata (in, DATA_WIDTH) to the instruction memory, whose read data appears one cycle after the address.
REQ-019 SHALL have port boot_done  out  1  high once the FSM is in RUN.

Function
REQ-020 SHALL implement FSM states BOOT and RUN; BOOT -> RUN on the cycle after l_done=1 sampled; RUN is terminal until reset.
REQ-021 In BOOT: f_gnt=0 always; l_gnt=l_req.
REQ-022 In RUN: grant combinational, same cycle as request; at most one of f_gnt/l_gnt high per cycle; fixed priority loader over fetch.
REQ-023 mem_addr SHALL be l_addr when l_gnt, else f_addr; mem_we=l_gnt&l_we; mem_wdata=l_wdata.
REQ-024 A granted read SHALL record a one-bit owner tag; the next cycle, the owner's rvalid=1 and its rdata=mem_rdata; the other rvalid=0.
REQ-025 Granted writes SHALL produce no rvalid.
REQ-026 Back-to-back grants SHALL sustain one access per cycle, with no bubble between owners.
REQ-027 l_done with l_req in the same cycle: that request SHALL still be served under BOOT rules.
REQ-028 rdata outputs SHALL hold their last value when rvalid=0.

Reset
REQ-029 rst=0 at a clock edge SHALL force BOOT, boot_done=0, rvalid outputs=0, rdata outputs=0, owner tag and RR pointer=0.
REQ-030 Reset mid-operation SHALL drop any pending read return; no rvalid in the cycle after reset deasserts.
REQ-031 While rst=0, grants and mem_we SHALL be 0.

Configuration
REQ-032 Macro IMEM_ARB_RR_EN defined: in RUN, when both request, the grant SHALL go to the requester not granted most recently (1-bit pointer, updated on every grant). Undefined: fixed loader priority per REQ-022.

Verification
REQ-033 Reset, then f_req=1 for 5 cycles in BOOT -> f_gnt=0 throughout, boot_done=0.
REQ-034 BOOT: loader writes 0x20080005 to address 0 and 0x20090003 to address 1, then pulses l_done -> mem_we high exactly 2 cycles; boot_done=1 the cycle after l_done.
REQ-035 RUN: f_req on addresses 0..9, one per cycle -> f_rvalid every cycle from the 2nd cycle on; f_rdata(0)=0x20080005, f_rdata(1)=0x20090003.
REQ-036 RUN: f_req and l_req (read, address 1) together for 4 cycles -> without macro, l_gnt x4 and f_gnt x0; with IMEM_ARB_RR_EN, grants alternate L,F,L,F.
REQ-037 Fetch read granted, then rst=0 on the next edge -> f_rvalid=0, boot_done=0, all outputs at reset values.
